cineraria_core_gpio_edgecap: RTL

//  Input-conditioning and edge-capture stage sitting directly upstream of the GPIO

---
 rtl/cineraria_core_gpio_edgecap.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cineraria_core_gpio_edgecap.sv
// ============================================================================
// cineraria_core_gpio_edgecap
//   Pad input synchroniser, tick-based debounce filter and per-bit edge capture.
//   It has an Avalon-MM slave for mask, edge select and W1C capture, plus a level IRQ.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module cineraria_core_gpio_edgecap #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE   = 1000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_filt,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_PIN  = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd2;
  localparam logic [1:0] ADDR_ESEL = 2'd3;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_filt;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_next;
  logic             wr_en;

  // Two-flop synchroniser: pin_in is fully asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pin_in;
      sync_q    <= sync_meta;
    end
  end

  generate
    if (FILTER_LEN > 0) begin : g_filter
      localparam logic [15:0] PS_LAST  = 16'(PRESCALE - 1);
      localparam logic [3:0]  CNT_LAST = 4'(FILTER_LEN - 1);

      logic [15:0] ps_cnt;
      logic        tick;
      logic [3:0]  cnt [WIDTH];

      assign tick = (ps_cnt == PS_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ps_cnt <= '0;
        end else if (tick) begin
          ps_cnt <= '0;
        end else begin
          ps_cnt <= ps_cnt + 16'd1;
        end
      end

      // A new level is accepted only after FILTER_LEN consecutive differing ticks.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pin_filt <= '0;
          for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
          end
        end else if (tick) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == pin_filt[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              pin_filt[i] <= sync_q[i];
              cnt[i]      <= '0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end
        end
      end
    end else begin : g_bypass
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pin_filt <= '0;
        end else begin
          pin_filt <= sync_q;
        end
      end
    end
  endgenerate

  assign rise  = pin_filt & ~prev_filt;
  assign fall  = ~pin_filt & prev_filt;
  assign ev    = (edge_sel & fall) | (~edge_sel & rise);
  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign clr   = (wr_en && address == ADDR_CAP) ? wdata : '0;

  // New events are ORed in after the clear, so a same-cycle set beats W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_filt <= '0;
      cap       <= '0;
      irq_mask  <= '0;
      edge_sel  <= '0;
    end else begin
      prev_filt <= pin_filt;
      cap       <= (cap & ~clr) | ev;
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= wdata;
      end
      if (wr_en && address == ADDR_ESEL) begin
        edge_sel <= wdata;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_PIN:  rd_next[WIDTH-1:0] = pin_filt;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_CAP:  rd_next[WIDTH-1:0] = cap;
      ADDR_ESEL: rd_next[WIDTH-1:0] = edge_sel;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= |(cap & irq_mask);
    end
  end

endmodule

`default_nettype wire
